// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: controller
// state encoding and the stall/bubble bit index of each pipeline register.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } pc_state_e;

    // Bit positions inside the stall/bubble vectors.
    localparam int IDX_PC    = 0;
    localparam int IDX_IFID  = 1;
    localparam int IDX_IDEX  = 2;
    localparam int IDX_EXMEM = 3;
    localparam int IDX_MEMWB = 4;
    localparam int NUM_REGS  = 5;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Clear, or count up and stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the five-stage pipeline. Stall requests
// are resolved combinationally (oldest stage wins); exceptions are held until
// the MEM stage is free and then turned into a one-cycle registered flush.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_if,
    input  logic                  req_id,
    input  logic                  req_ex,
    input  logic                  req_mem,
    input  logic                  exc_valid,
    input  logic [ADDR_WIDTH-1:0] exc_pc,
    input  logic                  cnt_clr,
    output logic [NUM_REGS-1:0]   stall,
    output logic [NUM_REGS-1:0]   bubble,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] flush_pc,
    output logic [CNT_WIDTH-1:0]  stall_cycles,
    output logic [1:0]            dbg_state
);

    pc_state_e             state_q;
    logic [ADDR_WIDTH-1:0] exc_pc_q;
    logic                  flush_q;
    logic [ADDR_WIDTH-1:0] flush_pc_q;

    // Stall resolver: MEM-level hold also covers a fresh or pending exception.
    always_comb begin
        stall  = '0;
        bubble = '0;
        if (!rst && (state_q != ST_FLUSH)) begin
            if (req_mem || exc_valid || (state_q == ST_WAIT)) begin
                stall[IDX_PC]     = 1'b1;
                stall[IDX_IFID]   = 1'b1;
                stall[IDX_IDEX]   = 1'b1;
                stall[IDX_EXMEM]  = 1'b1;
                bubble[IDX_MEMWB] = 1'b1;
            end else if (req_ex) begin
                stall[IDX_PC]     = 1'b1;
                stall[IDX_IFID]   = 1'b1;
                stall[IDX_IDEX]   = 1'b1;
                bubble[IDX_EXMEM] = 1'b1;
            end else if (req_id) begin
                stall[IDX_PC]     = 1'b1;
                stall[IDX_IFID]   = 1'b1;
                bubble[IDX_IDEX]  = 1'b1;
            end else if (req_if) begin
                stall[IDX_PC]     = 1'b1;
                bubble[IDX_IFID]  = 1'b1;
            end
        end
    end

    // Exception sequencer: capture in RUN, wait out MEM stall, flush one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            exc_pc_q   <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (exc_valid) begin
                        exc_pc_q <= exc_pc;
                        if (!req_mem) begin
                            state_q    <= ST_FLUSH;
                            flush_q    <= 1'b1;
                            flush_pc_q <= exc_pc;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req_mem) begin
                        state_q    <= ST_FLUSH;
                        flush_q    <= 1'b1;
                        flush_pc_q <= exc_pc_q;
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .inc_i  (stall[IDX_PC]),
        .count_o(stall_cycles)
    );

    assign flush     = flush_q;
    assign flush_pc  = flush_pc_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl (4-bit counter build). Expected outputs come from a
// cycle-level model of the controller rules: stall depth = oldest requesting
// stage, exceptions pending until MEM frees, flush one cycle later.
module tb_pipeline_ctrl;

    localparam int CW = 4;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_if, req_id, req_ex, req_mem;
    logic          exc_valid;
    logic [AW-1:0] exc_pc;
    logic          cnt_clr;
    logic [4:0]    stall, bubble;
    logic          flush;
    logic [AW-1:0] flush_pc;
    logic [CW-1:0] stall_cycles;
    logic [1:0]    dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state
    bit            m_pending;
    bit            m_flushing;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_flush_pc;
    logic [CW-1:0] m_cnt;

    pipeline_ctrl #(.CNT_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_if      (req_if),
        .req_id      (req_id),
        .req_ex      (req_ex),
        .req_mem     (req_mem),
        .exc_valid   (exc_valid),
        .exc_pc      (exc_pc),
        .cnt_clr     (cnt_clr),
        .stall       (stall),
        .bubble      (bubble),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .stall_cycles(stall_cycles),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pending  = 0;
        m_flushing = 0;
        m_pc       = '0;
        m_flush_pc = '0;
        m_cnt      = '0;
    endtask

    // One cycle: drive, check mid-cycle, advance model, cross the clock edge.
    task automatic step(input logic [3:0] req, input bit exc, input logic [AW-1:0] pc,
                        input bit clr);
        int         level;
        logic [4:0] e_stall, e_bubble;
        {req_mem, req_ex, req_id, req_if} = req;
        exc_valid = exc;
        exc_pc    = pc;
        cnt_clr   = clr;
        #3;
        level = 0;
        if (!m_flushing) begin
            for (int k = 1; k <= 4; k++) if (req[k-1]) level = k;
            if (m_pending || exc) level = 4;
        end
        e_stall  = 5'((1 << level) - 1);
        e_bubble = (level == 0) ? 5'd0 : 5'(1 << level);
        check("stall", 32'(stall), 32'(e_stall));
        check("bubble", 32'(bubble), 32'(e_bubble));
        check("flush", 32'(flush), 32'(m_flushing));
        check("flush_pc", flush_pc, m_flush_pc);
        check("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
        // Model advance at the coming edge
        if (clr) m_cnt = '0;
        else if (e_stall[0] && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        if (m_flushing) begin
            m_flushing = 0;
        end else begin
            if (exc && !m_pending) begin
                m_pending = 1;
                m_pc      = pc;
            end
            if (m_pending && !req[3]) begin
                m_pending  = 0;
                m_flushing = 1;
                m_flush_pc = m_pc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {req_mem, req_ex, req_id, req_if} = 4'b0;
        exc_valid = 1'b0;
        cnt_clr   = 1'b0;
        #1;
        model_reset();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_bubble", 32'(bubble), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_flush_pc", flush_pc, 32'd0);
        check("rst_cnt", 32'(stall_cycles), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        exc_pc = '0;
        do_reset();

        // Priority: oldest requester wins, MEM overrides same cycle
        step(4'b0111, 0, '0, 0);
        step(4'b1111, 0, '0, 0);

        // Exception with no MEM stall: flush next cycle, then drop
        step(4'b0000, 1, 32'hBFC00380, 0);
        step(4'b0000, 0, '0, 0);
        step(4'b0000, 0, '0, 0);

        // Exception during MEM stall; second exception in WAIT is ignored
        step(4'b1000, 1, 32'h00001000, 0);
        step(4'b1000, 1, 32'h80000180, 0);
        step(4'b1000, 0, '0, 0);
        step(4'b0010, 0, '0, 0);
        // FLUSH cycle with MEM request and exception present: both ignored
        step(4'b1000, 1, 32'h12345678, 0);
        step(4'b0000, 0, '0, 0);
        step(4'b0000, 0, '0, 0);

        // Reset in the middle of WAIT drops the exception
        step(4'b1000, 1, 32'hDEAD0000, 0);
        step(4'b1000, 0, '0, 0);
        #2;
        do_reset();
        step(4'b0000, 0, '0, 0);
        step(4'b0000, 0, '0, 0);

        // Counter saturation, then clear beats increment
        for (int i = 0; i < 20; i++) step(4'b0001, 0, '0, 0);
        step(4'b0001, 0, '0, 1);
        step(4'b0000, 0, '0, 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r[0] = ($urandom_range(0, 3) == 0);
            r[1] = ($urandom_range(0, 3) == 0);
            r[2] = ($urandom_range(0, 3) == 0);
            r[3] = ($urandom_range(0, 2) == 0);
            step(r, ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
